// File: rtl/jtdsp16_aau_multi_if.sv
// Decoder-side bus of the multi-pointer RAM address arithmetic unit.
// The master drives the access, update and register-file controls. The slave
// (the AAU) returns the register read-back and the registered RAM address.
interface jtdsp16_aau_multi_if #(
    parameter int AW = 11,
    parameter int DW = 16
);
    logic          cen;
    logic          upd_en;
    logic [2:0]    ptr_sel;
    logic [1:0]    inc_sel;
    logic          step_sel;
    logic [2:0]    mod_sel;
    logic          brev;
    logic          circ_dis;
    logic          wr_en;
    logic [4:0]    wr_idx;
    logic [DW-1:0] wr_data;
    logic [4:0]    rd_idx;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] addr;
    logic          addr_valid;
    logic          wrapped;

    modport master (
        output cen, upd_en, ptr_sel, inc_sel, step_sel, mod_sel, brev, circ_dis,
        output wr_en, wr_idx, wr_data, rd_idx,
        input  rd_data, addr, addr_valid, wrapped
    );

    modport slave (
        input  cen, upd_en, ptr_sel, inc_sel, step_sel, mod_sel, brev, circ_dis,
        input  wr_en, wr_idx, wr_data, rd_idx,
        output rd_data, addr, addr_valid, wrapped
    );
endinterface

// File: rtl/jtdsp16_aau_multi.sv
// Multi-pointer RAM address arithmetic unit.
// NPTR pointers, each with its own circular base/end pair, and NMOD shared
// modifiers. Each update issues the current pointer as a registered RAM
// address and then post-modifies the pointer. The post-modify is a linear
// step with optional circular wrap, or a bit-reversed step for FFT addressing.
// Index slots at or above NPTR/NMOD are tied to zero. Out-of-range reads and
// accesses therefore return 0, and a modifier index that is out of range
// gives a zero step.
module jtdsp16_aau_multi #(
    parameter int AW   = 11,
    parameter int DW   = 16,
    parameter int NPTR = 4,
    parameter int NMOD = 2
) (
    input  logic               clk,
    input  logic               rst,
    jtdsp16_aau_multi_if.slave bus
);

    logic [AW-1:0] p_arr [0:7];
    logic [AW-1:0] b_arr [0:7];
    logic [AW-1:0] e_arr [0:7];
    logic [AW-1:0] m_arr [0:7];

    logic [AW-1:0] wr_lo;
    logic [AW-1:0] wr_mod;
    logic [AW-1:0] rd_val;
    logic          rd_is_mod;

    logic [AW-1:0] cur_p;
    logic [AW-1:0] cur_b;
    logic [AW-1:0] cur_e;
    logic [AW-1:0] unit_step;
    logic [AW-1:0] step;
    logic [AW-1:0] lin_sum;
    logic [AW-1:0] rev_sum;
    logic [AW-1:0] next_p;
    logic          step_pos;
    logic          step_neg;
    logic          circ_act;
    logic          do_wrap;
    logic          wr_same_ptr;

    logic [AW-1:0] addr_reg;
    logic          addr_valid_reg;
    logic          wrapped_reg;

    function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = v[AW-1-i];
        end
        return r;
    endfunction

    // Pointer, base and end take the low AW bits. Modifiers are sign-adjusted to AW bits.
    assign wr_lo  = AW'(bus.wr_data);
    assign wr_mod = AW'($signed(bus.wr_data));

    // Per-slot pointer/base/end registers. Slots at or above NPTR read as 0.
    for (genvar gi = 0; gi < 8; gi++) begin : g_ptr
        if (gi < NPTR) begin : g_on
            logic [AW-1:0] p_reg;
            logic [AW-1:0] b_reg;
            logic [AW-1:0] e_reg;

            // A register write has priority over the post-modify of the same pointer.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_reg <= '0;
                    b_reg <= '0;
                    e_reg <= '0;
                end else if (bus.cen) begin
                    if (bus.wr_en && bus.wr_idx == {2'd0, 3'(gi)})
                        p_reg <= wr_lo;
                    else if (bus.upd_en && bus.ptr_sel == 3'(gi))
                        p_reg <= next_p;
                    if (bus.wr_en && bus.wr_idx == {2'd1, 3'(gi)})
                        b_reg <= wr_lo;
                    if (bus.wr_en && bus.wr_idx == {2'd2, 3'(gi)})
                        e_reg <= wr_lo;
                end
            end

            assign p_arr[gi] = p_reg;
            assign b_arr[gi] = b_reg;
            assign e_arr[gi] = e_reg;
        end else begin : g_off
            assign p_arr[gi] = '0;
            assign b_arr[gi] = '0;
            assign e_arr[gi] = '0;
        end
    end

    // Shared modifier registers. Slots at or above NMOD read as 0.
    for (genvar gi = 0; gi < 8; gi++) begin : g_mod
        if (gi < NMOD) begin : g_on
            logic [AW-1:0] m_reg;

            // Modifier load.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    m_reg <= '0;
                else if (bus.cen && bus.wr_en && bus.wr_idx == {2'd3, 3'(gi)})
                    m_reg <= wr_mod;
            end

            assign m_arr[gi] = m_reg;
        end else begin : g_off
            assign m_arr[gi] = '0;
        end
    end

    // Combinational read-back mux. Only modifiers are sign-extended.
    always_comb begin
        rd_val    = '0;
        rd_is_mod = 1'b0;
        case (bus.rd_idx[4:3])
            2'd0:    rd_val = p_arr[bus.rd_idx[2:0]];
            2'd1:    rd_val = b_arr[bus.rd_idx[2:0]];
            2'd2:    rd_val = e_arr[bus.rd_idx[2:0]];
            default: begin
                rd_val    = m_arr[bus.rd_idx[2:0]];
                rd_is_mod = 1'b1;
            end
        endcase
    end

    assign bus.rd_data = rd_is_mod ? DW'($signed(rd_val)) : DW'(rd_val);

    assign cur_p = p_arr[bus.ptr_sel];
    assign cur_b = b_arr[bus.ptr_sel];
    assign cur_e = e_arr[bus.ptr_sel];

    // Unit step decode: -1, 0, +1, +2.
    always_comb begin
        unit_step = '0;
        case (bus.inc_sel)
            2'd0:    unit_step = '1;
            2'd1:    unit_step = '0;
            2'd2:    unit_step = AW'(1);
            default: unit_step = AW'(2);
        endcase
    end

    assign step     = bus.step_sel ? m_arr[bus.mod_sel] : unit_step;
    assign lin_sum  = cur_p + step;
    assign rev_sum  = bit_rev(bit_rev(cur_p) + bit_rev(step));
    assign step_neg = step[AW-1];
    assign step_pos = !step[AW-1] && (step != '0);

    // A circular buffer is enabled by a non-zero end. Wrap happens only on an exact hit of the boundary.
    assign circ_act = (cur_e != '0) && !bus.circ_dis && !bus.brev;
    assign do_wrap  = circ_act && ((step_pos && cur_p == cur_e) ||
                                   (step_neg && cur_p == cur_b));

    // Next pointer value: wrap target, bit-reversed sum or linear sum.
    always_comb begin
        next_p = bus.brev ? rev_sum : lin_sum;
        if (do_wrap)
            next_p = step_pos ? cur_b : cur_e;
    end

    // A write to the updated pointer in the same cycle cancels the wrap indication.
    assign wr_same_ptr = bus.wr_en && bus.wr_idx[4:3] == 2'd0 &&
                         bus.wr_idx[2:0] == bus.ptr_sel;

    // Registered RAM address, its valid flag and the one-cycle wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg       <= '0;
            addr_valid_reg <= 1'b0;
            wrapped_reg    <= 1'b0;
        end else if (bus.cen) begin
            if (bus.upd_en) begin
                addr_reg       <= cur_p;
                addr_valid_reg <= 1'b1;
                wrapped_reg    <= do_wrap && !wr_same_ptr;
            end else begin
                addr_valid_reg <= 1'b0;
                wrapped_reg    <= 1'b0;
            end
        end
    end

    assign bus.addr       = addr_reg;
    assign bus.addr_valid = addr_valid_reg;
    assign bus.wrapped    = wrapped_reg;

endmodule

// File: tb/tb_jtdsp16_aau_multi.sv
// Self-checking bench for jtdsp16_aau_multi. The bench runs directed steps,
// then a randomized phase. A small register-file model, written from the
// addressing rules, supplies every expected value. A second AW=3 instance
// exercises the bit-reversed FFT sequence.
module tb_jtdsp16_aau_multi;

    localparam int AW   = 11;
    localparam int DW   = 16;
    localparam int NPTR = 4;
    localparam int NMOD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    jtdsp16_aau_multi_if #(.AW(AW), .DW(DW)) bus ();
    jtdsp16_aau_multi_if #(.AW(3),  .DW(DW)) bus3 ();

    jtdsp16_aau_multi #(.AW(AW), .DW(DW), .NPTR(NPTR), .NMOD(NMOD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    jtdsp16_aau_multi #(.AW(3), .DW(DW), .NPTR(NPTR), .NMOD(NMOD)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model state
    logic [10:0] mp [8];
    logic [10:0] mb [8];
    logic [10:0] me [8];
    logic [10:0] mm [8];
    logic [10:0] exp_addr;
    logic        exp_valid;
    logic        exp_wrapped;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [10:0] rev11(input logic [10:0] v);
        logic [10:0] r;
        for (int i = 0; i < 11; i++) r[i] = v[10-i];
        return r;
    endfunction

    function automatic logic [15:0] model_rd(input logic [4:0] idx);
        int ix;
        ix = int'(idx[2:0]);
        case (idx[4:3])
            2'd0:    return {5'd0, mp[ix]};
            2'd1:    return {5'd0, mb[ix]};
            2'd2:    return {5'd0, me[ix]};
            default: return {{5{mm[ix][10]}}, mm[ix]};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mp[i] = '0; mb[i] = '0; me[i] = '0; mm[i] = '0;
        end
        exp_addr    = '0;
        exp_valid   = 1'b0;
        exp_wrapped = 1'b0;
    endtask

    // One clock edge of the architectural behaviour, evaluated on the inputs present before the edge
    task automatic model_step();
        int          pi, s, ix;
        logic [10:0] p, np;
        bit          nw;
        if (!bus.cen) return;
        pi = int'(bus.ptr_sel);
        if (bus.upd_en) begin
            p         = mp[pi];
            exp_addr  = p;
            exp_valid = 1'b1;
            if (bus.step_sel)
                s = (int'(bus.mod_sel) < NMOD) ? int'($signed(mm[bus.mod_sel])) : 0;
            else
                s = int'(bus.inc_sel) - 1;
            nw = 0;
            if (bus.brev)
                np = rev11(rev11(p) + rev11(11'(s)));
            else if (me[pi] != 0 && !bus.circ_dis && s > 0 && p == me[pi]) begin
                np = mb[pi]; nw = 1;
            end else if (me[pi] != 0 && !bus.circ_dis && s < 0 && p == mb[pi]) begin
                np = me[pi]; nw = 1;
            end else
                np = 11'(int'(p) + s);
            exp_wrapped = nw;
            if (pi < NPTR) mp[pi] = np;
        end else begin
            exp_valid   = 1'b0;
            exp_wrapped = 1'b0;
        end
        if (bus.wr_en) begin
            ix = int'(bus.wr_idx[2:0]);
            case (bus.wr_idx[4:3])
                2'd0: if (ix < NPTR) mp[ix] = bus.wr_data[10:0];
                2'd1: if (ix < NPTR) mb[ix] = bus.wr_data[10:0];
                2'd2: if (ix < NPTR) me[ix] = bus.wr_data[10:0];
                default: if (ix < NMOD) mm[ix] = bus.wr_data[10:0];
            endcase
            if (bus.wr_idx[4:3] == 2'd0 && ix == pi && bus.upd_en) exp_wrapped = 1'b0;
        end
    endtask

    task automatic do_cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        txn++;
        check({tag, ".addr"},    32'(bus.addr),       32'(exp_addr));
        check({tag, ".valid"},   32'(bus.addr_valid), 32'(exp_valid));
        check({tag, ".wrapped"}, 32'(bus.wrapped),    32'(exp_wrapped));
        check({tag, ".rd_data"}, 32'(bus.rd_data),    32'(model_rd(bus.rd_idx)));
        $display("txn %0d %s: cen=%b upd=%b ptr=%0d wr=%b idx=%h data=%h -> addr=%h valid=%b wrapped=%b rd[%h]=%h",
                 txn, tag, bus.cen, bus.upd_en, bus.ptr_sel, bus.wr_en, bus.wr_idx, bus.wr_data,
                 bus.addr, bus.addr_valid, bus.wrapped, bus.rd_idx, bus.rd_data);
    endtask

    task automatic idle();
        bus.cen = 1'b1; bus.upd_en = 1'b0; bus.ptr_sel = '0; bus.inc_sel = 2'd1;
        bus.step_sel = 1'b0; bus.mod_sel = '0; bus.brev = 1'b0; bus.circ_dis = 1'b0;
        bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_data = '0; bus.rd_idx = '0;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [15:0] data);
        idle();
        bus.wr_en = 1'b1; bus.wr_idx = idx; bus.wr_data = data;
        do_cycle("write");
    endtask

    task automatic upd(input logic [2:0] p, input logic [1:0] inc, input logic [4:0] rdi);
        idle();
        bus.upd_en = 1'b1; bus.ptr_sel = p; bus.inc_sel = inc; bus.rd_idx = rdi;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            bus.rd_idx = 5'(i);
            #1;
            check(tag, 32'(bus.rd_data), 32'd0);
        end
    endtask

    logic [2:0] fft_seq [9];

    initial begin
        fft_seq = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7, 3'd0};
        idle();
        bus3.cen = 1'b1; bus3.upd_en = 1'b0; bus3.ptr_sel = '0; bus3.inc_sel = 2'd1;
        bus3.step_sel = 1'b0; bus3.mod_sel = '0; bus3.brev = 1'b0; bus3.circ_dis = 1'b0;
        bus3.wr_en = 1'b0; bus3.wr_idx = '0; bus3.wr_data = '0; bus3.rd_idx = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.addr",    32'(bus.addr),       32'd0);
        check("reset.valid",   32'(bus.addr_valid), 32'd0);
        check("reset.wrapped", 32'(bus.wrapped),    32'd0);
        check_all_zero("reset.rd");
        @(negedge clk);
        rst = 1'b0;

        // Linear +1 run on P0
        for (int i = 0; i < 4; i++) begin
            upd(3'd0, 2'd2, 5'd0);
            do_cycle("lin");
            check("lin.addr_seq", 32'(bus.addr), 32'(i));
            check("lin.valid_seq", 32'(bus.addr_valid), 32'd1);
        end
        idle();
        do_cycle("lin_rd");
        check("lin.p0_final", 32'(bus.rd_data), 32'd4);
        check("lin.valid_drop", 32'(bus.addr_valid), 32'd0);

        // Circular buffer 0x10..0x13 on pointer 1
        wr(5'd9,  16'h0010);
        wr(5'd17, 16'h0013);
        wr(5'd1,  16'h0012);
        for (int i = 0; i < 4; i++) begin
            upd(3'd1, 2'd2, 5'd1);
            do_cycle("circ_fwd");
            check("circ_fwd.addr", 32'(bus.addr), (i == 0) ? 32'h12 : (i == 1) ? 32'h13 :
                                                  (i == 2) ? 32'h10 : 32'h11);
            check("circ_fwd.wrapped", 32'(bus.wrapped), (i == 1) ? 32'd1 : 32'd0);
        end

        // Backward wrap, then the same step with the wrap suppressed
        wr(5'd1, 16'h0010);
        upd(3'd1, 2'd0, 5'd1);
        do_cycle("circ_bwd");
        check("circ_bwd.wrapped", 32'(bus.wrapped), 32'd1);
        check("circ_bwd.p1", 32'(bus.rd_data), 32'h13);
        wr(5'd1, 16'h0010);
        upd(3'd1, 2'd0, 5'd1);
        bus.circ_dis = 1'b1;
        do_cycle("circ_dis");
        check("circ_dis.wrapped", 32'(bus.wrapped), 32'd0);
        check("circ_dis.p1", 32'(bus.rd_data), 32'h0F);

        // Negative modifier step, then a write colliding with the update
        wr(5'd25, 16'hFFFD);
        wr(5'd3,  16'h0005);
        idle();
        bus.rd_idx = 5'd25;
        #1;
        check("mod.sext_rd", 32'(bus.rd_data), 32'hFFFD);
        upd(3'd3, 2'd1, 5'd3);
        bus.step_sel = 1'b1; bus.mod_sel = 3'd1;
        do_cycle("mod_step");
        check("mod_step.p3", 32'(bus.rd_data), 32'd2);
        wr(5'd3, 16'h0005);
        upd(3'd3, 2'd2, 5'd3);
        bus.wr_en = 1'b1; bus.wr_idx = 5'd3; bus.wr_data = 16'h0040;
        do_cycle("collide");
        check("collide.addr", 32'(bus.addr), 32'd5);
        check("collide.p3", 32'(bus.rd_data), 32'h40);

        // Clock enable low freezes everything
        upd(3'd0, 2'd2, 5'd0);
        bus.cen = 1'b0; bus.wr_en = 1'b1; bus.wr_idx = 5'd0; bus.wr_data = 16'h0055;
        do_cycle("cen_low");
        check("cen_low.addr", 32'(bus.addr), 32'd5);
        check("cen_low.p0", 32'(bus.rd_data), 32'd4);

        // Out-of-range pointer issue and out-of-range write
        upd(3'd6, 2'd2, 5'd6);
        bus.wr_en = 1'b1; bus.wr_idx = 5'd30; bus.wr_data = 16'h1234;
        do_cycle("oor");
        check("oor.addr", 32'(bus.addr), 32'd0);
        bus.rd_idx = 5'd30;
        #1;
        check("oor.rd_mod6", 32'(bus.rd_data), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            bus.cen      = ($urandom_range(0, 9) != 0);
            bus.upd_en   = ($urandom_range(0, 3) != 0);
            bus.ptr_sel  = 3'($urandom_range(0, 4));
            bus.inc_sel  = 2'($urandom);
            bus.step_sel = ($urandom_range(0, 3) == 0);
            bus.mod_sel  = 3'($urandom_range(0, 2));
            bus.brev     = ($urandom_range(0, 7) == 0);
            bus.circ_dis = ($urandom_range(0, 7) == 0);
            bus.wr_en    = ($urandom_range(0, 3) == 0);
            bus.wr_idx   = 5'($urandom);
            bus.wr_data  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 24));
            bus.rd_idx   = 5'($urandom);
            do_cycle("rand");
        end

        // Asynchronous reset in the middle of a stream
        upd(3'd1, 2'd2, 5'd1);
        do_cycle("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("mid_rst.valid", 32'(bus.addr_valid), 32'd0);
        check("mid_rst.addr", 32'(bus.addr), 32'd0);
        check_all_zero("mid_rst.rd");
        idle();
        @(negedge clk);
        rst = 1'b0;
        upd(3'd0, 2'd2, 5'd0);
        do_cycle("post_rst");
        check("post_rst.addr", 32'(bus.addr), 32'd0);
        check("post_rst.p0", 32'(bus.rd_data), 32'd1);

        // Bit-reversed FFT addressing on the AW=3 instance
        bus3.wr_en = 1'b1; bus3.wr_idx = 5'd24; bus3.wr_data = 16'd4;
        @(posedge clk);
        #1;
        bus3.wr_en = 1'b0;
        bus3.upd_en = 1'b1; bus3.ptr_sel = 3'd2; bus3.step_sel = 1'b1;
        bus3.mod_sel = 3'd0; bus3.brev = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            txn++;
            check("fft.addr", 32'(bus3.addr), 32'(fft_seq[i]));
            check("fft.wrapped", 32'(bus3.wrapped), 32'd0);
            $display("txn %0d fft: step %0d addr=%0d valid=%b", txn, i, bus3.addr, bus3.addr_valid);
        end
        bus3.upd_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
